// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : shared owner encoding for the fetch/data memory arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
// ============================================================================
// rr_pick2 : two-way round-robin picker, fetch vs data
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic   req_fetch_i,
    input  logic   req_data_i,
    input  owner_e last_owner_i,
    output logic   gnt_fetch_o,
    output logic   gnt_data_o
);

    // On a conflict the side that did not win last time goes next.
    assign gnt_data_o  = req_data_i & (~req_fetch_i | (last_owner_i != OWN_DATA));
    assign gnt_fetch_o = req_fetch_i & ~gnt_data_o;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one single-port memory between instruction fetch and
//               data load/store requesters, round-robin on conflict
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,

    input  logic              d_valid,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata
);

    owner_e last_owner_q, last_owner_d;
    owner_e resp_owner_q, resp_owner_d;
    logic   resp_is_store_q, resp_is_store_d;

    logic   gnt_fetch;
    logic   gnt_data;

    // Byte-offset and high address bits are intentionally dropped.
    logic   unused_addr_bits;
    assign  unused_addr_bits = ^{i_addr, d_addr};

    rr_pick2 u_pick (
        .req_fetch_i  (i_valid & ~reset),
        .req_data_i   (d_valid & ~reset),
        .last_owner_i (last_owner_q),
        .gnt_fetch_o  (gnt_fetch),
        .gnt_data_o   (gnt_data)
    );

    assign i_ready = gnt_fetch;
    assign d_ready = gnt_data;

    always_comb begin
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_wstrb       = '0;
        last_owner_d    = last_owner_q;
        resp_owner_d    = OWN_NONE;
        resp_is_store_d = 1'b0;
        if (gnt_data) begin
            mem_en          = 1'b1;
            mem_we          = d_we;
            mem_addr        = d_addr[MEM_AW+1:2];
            mem_wdata       = d_wdata;
            mem_wstrb       = d_we ? d_wstrb : 4'b0000;
            last_owner_d    = OWN_DATA;
            resp_owner_d    = OWN_DATA;
            resp_is_store_d = d_we;
        end else if (gnt_fetch) begin
            mem_en       = 1'b1;
            mem_addr     = i_addr[MEM_AW+1:2];
            last_owner_d = OWN_FETCH;
            resp_owner_d = OWN_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q    <= OWN_FETCH;
            resp_owner_q    <= OWN_NONE;
            resp_is_store_q <= 1'b0;
        end else begin
            last_owner_q    <= last_owner_d;
            resp_owner_q    <= resp_owner_d;
            resp_is_store_q <= resp_is_store_d;
        end
    end

    // Responses are masked during reset so one in flight at assertion is dropped.
    always_comb begin
        i_rvalid = ~reset & (resp_owner_q == OWN_FETCH);
        d_rvalid = ~reset & (resp_owner_q == OWN_DATA);
        i_rdata  = i_rvalid ? mem_rdata : 32'h0;
        d_rdata  = (d_rvalid && !resp_is_store_q) ? mem_rdata : 32'h0;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed, table-driven bench for mem_arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_valid, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .MEM_AW(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_valid   (d_valid),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ready   (d_ready),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    // Memory: word k holds A000_0000+k after reset; one-cycle read latency.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 32'hA000_0000 + 32'(k);
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    typedef struct {
        logic        rst, iv;
        logic [31:0] ia;
        logic        dv, dwe;
        logic [31:0] da, dwd;
        logic [3:0]  dws;
        logic        e_ir, e_dr, e_en, e_we;
        logic [9:0]  e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_ws;
        logic        e_irv;
        logic [31:0] e_ird;
        logic        e_drv;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, iv, input logic [31:0] ia,
                       input logic dv, dwe, input logic [31:0] da, dwd, input logic [3:0] dws,
                       input logic e_ir, e_dr, e_en, e_we, input logic [9:0] e_addr,
                       input logic [31:0] e_wd, input logic [3:0] e_ws,
                       input logic e_irv, input logic [31:0] e_ird,
                       input logic e_drv, input logic [31:0] e_drd);
        vecs.push_back('{rst, iv, ia, dv, dwe, da, dwd, dws, e_ir, e_dr, e_en, e_we,
                         e_addr, e_wd, e_ws, e_irv, e_ird, e_drv, e_drd});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, iv, input logic [31:0] ia,
                         input logic dv, dwe, input logic [31:0] da, dwd, input logic [3:0] dws);
        reset   = rst;
        i_valid = iv;
        i_addr  = ia;
        d_valid = dv;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        d_wstrb = dws;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        //   rst iv ia     dv we da     dwd           dws  | ir dr en we addr wd            ws   irv ird           drv drd
        add(1, 1, 32'h8,  1, 0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 10'd0, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
        add(1, 0, 32'h0,  0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 0, 10'd0, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
        add(0, 1, 32'h8,  1, 0, 32'h10, 32'h0,        4'h0, 0, 1, 1, 0, 10'd4, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
        add(0, 1, 32'h8,  0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 1, 0, 10'd2, 32'h0,        4'h0, 0, 32'h0,        1, 32'hA0000004);
        add(0, 1, 32'h8,  0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 1, 0, 10'd2, 32'h0,        4'h0, 1, 32'hA0000002, 0, 32'h0);
        add(0, 1, 32'hC,  1, 0, 32'h10, 32'h0,        4'h0, 0, 1, 1, 0, 10'd4, 32'h0,        4'h0, 1, 32'hA0000002, 0, 32'h0);
        add(0, 1, 32'hC,  1, 0, 32'h10, 32'h0,        4'h0, 1, 0, 1, 0, 10'd3, 32'h0,        4'h0, 0, 32'h0,        1, 32'hA0000004);
        add(0, 1, 32'hC,  1, 0, 32'h10, 32'h0,        4'h0, 0, 1, 1, 0, 10'd4, 32'h0,        4'h0, 1, 32'hA0000003, 0, 32'h0);
        add(0, 0, 32'h0,  1, 1, 32'h20, 32'hDEADBEEF, 4'h3, 0, 1, 1, 1, 10'd8, 32'hDEADBEEF, 4'h3, 0, 32'h0,        1, 32'hA0000004);
        add(0, 0, 32'h0,  1, 0, 32'h22, 32'h0,        4'hF, 0, 1, 1, 0, 10'd8, 32'h0,        4'h0, 0, 32'h0,        1, 32'h0);
        add(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 0, 10'd0, 32'h0,        4'h0, 0, 32'h0,        1, 32'hA000BEEF);
        add(0, 1, 32'h4,  0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 1, 0, 10'd1, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
        add(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 0, 10'd0, 32'h0,        4'h0, 1, 32'hA0000001, 0, 32'h0);
        add(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 0, 10'd0, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
        add(0, 1, 32'h4,  1, 0, 32'h8,  32'h0,        4'h0, 0, 1, 1, 0, 10'd2, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
        add(0, 1, 32'h4,  0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 1, 0, 10'd1, 32'h0,        4'h0, 0, 32'h0,        1, 32'hA0000002);
        add(1, 1, 32'h4,  0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 0, 10'd0, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
        add(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 0, 10'd0, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
        add(0, 1, 32'h4,  1, 0, 32'h8,  32'h0,        4'h0, 0, 1, 1, 0, 10'd2, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].dwe,
                  vecs[i].da, vecs[i].dwd, vecs[i].dws);
            #1;
            chk($sformatf("v%0d i_ready", i),   32'(i_ready),   32'(vecs[i].e_ir));
            chk($sformatf("v%0d d_ready", i),   32'(d_ready),   32'(vecs[i].e_dr));
            chk($sformatf("v%0d mem_en", i),    32'(mem_en),    32'(vecs[i].e_en));
            chk($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(vecs[i].e_we));
            chk($sformatf("v%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_addr));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,      vecs[i].e_wd);
            chk($sformatf("v%0d mem_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].e_ws));
            chk($sformatf("v%0d i_rvalid", i),  32'(i_rvalid),  32'(vecs[i].e_irv));
            chk($sformatf("v%0d i_rdata", i),   i_rdata,        vecs[i].e_ird);
            chk($sformatf("v%0d d_rvalid", i),  32'(d_rvalid),  32'(vecs[i].e_drv));
            chk($sformatf("v%0d d_rdata", i),   d_rdata,        vecs[i].e_drd);
        end

        // Back-to-back fetch stream over words 0..7: one grant and one response per cycle.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(0, 1, 32'(4 * k), 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("stream%0d i_ready", k),  32'(i_ready),  32'h1);
            chk($sformatf("stream%0d mem_addr", k), 32'(mem_addr), 32'(k));
            if (k > 0) begin
                chk($sformatf("stream%0d i_rvalid", k), 32'(i_rvalid), 32'h1);
                chk($sformatf("stream%0d i_rdata", k),  i_rdata, 32'hA000_0000 + 32'(k - 1));
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("stream_tail i_rvalid", 32'(i_rvalid), 32'h1);
        chk("stream_tail i_rdata",  i_rdata,       32'hA000_0007);
        chk("stream_tail mem_en",   32'(mem_en),   32'h0);
        @(negedge clk);
        #1;
        chk("stream_idle i_rvalid", 32'(i_rvalid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
